// File: rtl/io_switch_port.sv
// Memory-mapped switch-bank input port: synchronises and debounces the switches,
// latches per-bit change flags with a maskable interrupt, and answers reads one cycle later.
module io_switch_port #(
  parameter int          WIDTH           = 8,
  parameter logic [15:0] SWITCH_ADDR     = 16'hCFFD,
  parameter logic [15:0] STATUS_ADDR     = 16'hCFFF,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic [15:0]      address,
  input  logic             wren,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             hit,
  output logic             irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, candidate, debounced, flags, mask;
  logic [CW-1:0]    cnt;

  logic             status_wr;
  logic             deb_update;
  logic [WIDTH-1:0] set_bits, w1c_bits;
  logic [15:0]      switch_word, status_word;

  // A debounced change and a W1C on the same bit resolve in favour of the set
  always_comb begin
    status_wr   = wren && (address == STATUS_ADDR);
    deb_update  = (s2 == candidate) && (cnt == CNT_MAX);
    set_bits    = deb_update ? (debounced ^ candidate) : '0;
    w1c_bits    = status_wr ? wdata[WIDTH-1:0] : '0;
    switch_word = '0;
    switch_word[WIDTH-1:0] = debounced;
    status_word = '0;
    status_word[WIDTH-1:0]       = flags;
    status_word[2*WIDTH-1:WIDTH] = mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      candidate <= '0;
      debounced <= '0;
      cnt       <= '0;
      flags     <= '0;
      mask      <= '0;
      rdata     <= '0;
      hit       <= 1'b0;
    end else begin
      s1 <= switches;
      s2 <= s1;

      // Shared counter: any bit moving restarts the stability window for all bits
      if (s2 != candidate) begin
        candidate <= s2;
        cnt       <= '0;
      end else if (cnt == CNT_MAX) begin
        debounced <= candidate;
      end else begin
        cnt <= cnt + 1'b1;
      end

      flags <= (flags & ~w1c_bits) | set_bits;
      if (status_wr) begin
        mask <= wdata[2*WIDTH-1:WIDTH];
      end

      // Read words are built from pre-edge state, so a same-cycle write is not visible yet
      if (address == SWITCH_ADDR) begin
        rdata <= switch_word;
        hit   <= 1'b1;
      end else if (address == STATUS_ADDR) begin
        rdata <= status_word;
        hit   <= 1'b1;
      end else begin
        rdata <= '0;
        hit   <= 1'b0;
      end
    end
  end

  assign irq = |(flags & mask);

endmodule

// File: tb/tb_io_switch_port.sv
// Self-checking bench for io_switch_port: directed steps plus random traffic,
// compared every cycle against a sample-window reference model.
module tb_io_switch_port;

  localparam int          D     = 4;
  localparam logic [15:0] SW_A  = 16'hCFFD;
  localparam logic [15:0] ST_A  = 16'hCFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switches;
  logic [15:0] address;
  logic        wren;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        hit;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: raw samples per edge, debounced value, flags, mask, read port
  logic [7:0]  hist[$];
  logic [7:0]  m_deb, m_flags, m_mask;
  logic [15:0] m_rdata;
  logic        m_hit;

  always #10 clk = ~clk;

  io_switch_port #(
    .WIDTH(8),
    .SWITCH_ADDR(SW_A),
    .STATUS_ADDR(ST_A),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .address(address),
    .wren(wren),
    .wdata(wdata),
    .rdata(rdata),
    .hit(hit),
    .irq(irq)
  );

  // A value is accepted once the sample taken two edges ago and the D samples
  // before it all agree; reset seeds three zero samples for the sync/candidate stages.
  function automatic void modelEdge();
    logic [7:0] set_bits, w1c, win;
    bit         stable;
    int         n;
    if (reset) begin
      m_deb = '0; m_flags = '0; m_mask = '0; m_rdata = '0; m_hit = 1'b0;
      hist = {8'h00, 8'h00, 8'h00};
      return;
    end
    if (address == SW_A) begin
      m_rdata = {8'h00, m_deb}; m_hit = 1'b1;
    end else if (address == ST_A) begin
      m_rdata = {m_mask, m_flags}; m_hit = 1'b1;
    end else begin
      m_rdata = '0; m_hit = 1'b0;
    end
    hist.push_back(switches);
    if (hist.size() > D + 3) void'(hist.pop_front());
    set_bits = '0;
    n = hist.size();
    if (n == D + 3) begin
      stable = 1'b1;
      win = hist[0];
      for (int i = 0; i <= D; i++) if (hist[i] !== win) stable = 1'b0;
      if (stable) begin
        set_bits = win ^ m_deb;
        m_deb = win;
      end
    end
    w1c = (wren && address == ST_A) ? wdata[7:0] : 8'h00;
    m_flags = (m_flags & ~w1c) | set_bits;
    if (wren && address == ST_A) m_mask = wdata[15:8];
  endfunction

  task automatic checkOutput();
    vectors++;
    assert (rdata === m_rdata) else begin
      miscompares++;
      $error("[TB] FAIL rdata observed=%h expected=%h", rdata, m_rdata);
    end
    vectors++;
    assert (hit === m_hit) else begin
      miscompares++;
      $error("[TB] FAIL hit observed=%b expected=%b", hit, m_hit);
    end
    vectors++;
    assert (irq === |(m_flags & m_mask)) else begin
      miscompares++;
      $error("[TB] FAIL irq observed=%b expected=%b", irq, |(m_flags & m_mask));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] sw, input logic [15:0] a,
                               input logic we, input logic [15:0] wd);
    reset = r; switches = sw; address = a; wren = we; wdata = wd;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    logic [7:0]  sw;
    logic [15:0] a;
    reset = 1'b1; switches = '0; address = '0; wren = 1'b0; wdata = '0;

    // Reset, then read both registers
    repeat (3) applyStimulus(1'b1, 8'h00, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'h00, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'h00, ST_A, 1'b0, 16'h0);
    repeat (6) applyStimulus(1'b0, 8'h00, SW_A, 1'b0, 16'h0);

    // Debounce latency: 0xA5 visible only after the full window
    repeat (10) applyStimulus(1'b0, 8'hA5, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA5, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA4, ST_A, 1'b1, 16'h00FF);
    repeat (8) applyStimulus(1'b0, 8'hA4, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA4, ST_A, 1'b1, 16'h00FF);

    // Glitch rejection on bit 0, then a long enough hold
    repeat (3) applyStimulus(1'b0, 8'hA5, SW_A, 1'b0, 16'h0);
    repeat (8) applyStimulus(1'b0, 8'hA4, ST_A, 1'b0, 16'h0);
    repeat (7) applyStimulus(1'b0, 8'hA5, ST_A, 1'b0, 16'h0);
    repeat (2) applyStimulus(1'b0, 8'hA5, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA5, ST_A, 1'b1, 16'h00FF);

    // Interrupt and W1C: flags become 0x05, then mask and clear
    repeat (8) applyStimulus(1'b0, 8'hA0, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA0, ST_A, 1'b1, 16'h0400);
    applyStimulus(1'b0, 8'hA0, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA0, ST_A, 1'b1, 16'h0404);
    applyStimulus(1'b0, 8'hA0, ST_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA0, ST_A, 1'b1, 16'h08FF);
    repeat (2) applyStimulus(1'b0, 8'hA0, SW_A, 1'b0, 16'h0);

    // Collision: bit 3 debounces on the same edge as its W1C
    repeat (6) applyStimulus(1'b0, 8'hA8, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA8, ST_A, 1'b1, 16'h0808);
    repeat (2) applyStimulus(1'b0, 8'hA8, ST_A, 1'b0, 16'h0);

    // Writes to the switch register, unmapped reads
    applyStimulus(1'b0, 8'hA8, SW_A, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 8'hA8, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA8, 16'h1234, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'hA8, ST_A, 1'b0, 16'h0);

    // Reset with a debounce pending, then a fresh full debounce
    repeat (4) applyStimulus(1'b0, 8'h3C, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b1, 8'h3C, SW_A, 1'b0, 16'h0);
    repeat (10) applyStimulus(1'b0, 8'h3C, SW_A, 1'b0, 16'h0);
    applyStimulus(1'b0, 8'h3C, ST_A, 1'b1, 16'hFF00);
    applyStimulus(1'b0, 8'h3C, ST_A, 1'b0, 16'h0);

    // Random traffic with slowly changing switches
    sw = 8'h3C;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) sw = sw ^ 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       a = SW_A;
        1:       a = ST_A;
        default: a = 16'($urandom_range(0, 65535));
      endcase
      applyStimulus($urandom_range(0, 149) == 0, sw, a, $urandom_range(0, 4) == 0,
                    16'($urandom_range(0, 65535)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
